// File: rtl/game_timing_pkg.sv
// Shared mode encodings and elaboration-time helpers for the game tick generator.
package game_timing_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_RUN   = 2'b00,
    MODE_STEP  = 2'b01,
    MODE_PAUSE = 2'b10
  } mode_e;

  // Clock cycles per frame tick (integer division, remainder dropped).
  function automatic int unsigned calc_frame_div(input int unsigned clk_hz,
                                                 input int unsigned frame_hz);
    return clk_hz / frame_hz;
  endfunction

  // Bits needed to count 0..n-1; never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((w < 32) && ((64'd1 << w) < 64'(n))) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser, stability-count debouncer and rising-edge pulse
// for an asynchronous, bouncing push-button.
module button_debouncer
  import game_timing_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk_50mhz,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_rise
);

  localparam int unsigned    CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             level_d;
  logic             level_dly_q;
  logic             rise_q;

  // Level flips once the synchronised input has disagreed for the full window;
  // any cycle of agreement restarts the count.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      rise_q      <= 1'b0;
    end else begin
      sync1_q     <= btn_in;
      sync2_q     <= sync1_q;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
      rise_q      <= level_q & ~level_dly_q;
    end
  end

  assign btn_level = level_q;
  assign btn_rise  = rise_q;

endmodule

// File: rtl/game_tick_generator.sv
// Single-clock enable generator: pixel enable, mode-gated frame tick,
// per-channel divided ticks and a wrapping frame counter.
module game_tick_generator
  import game_timing_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 50_000_000,
  parameter int unsigned FRAME_HZ        = 60,
  parameter int unsigned PIX_DIV         = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned CH_N            = 2,
  parameter int unsigned CH_DIV_W        = 8,
  parameter int unsigned FRAME_CNT_W     = 16
) (
  input  logic                       clk_50mhz,
  input  logic                       rst_n,
  input  logic [1:0]                 mode_sel,
  input  logic                       step_btn,
  input  logic [CH_N*CH_DIV_W-1:0]   ch_div,
  output logic                       pix_en,
  output logic                       frame_tick,
  output logic [CH_N-1:0]            ch_tick,
  output logic [FRAME_CNT_W-1:0]     frame_count,
  output logic [1:0]                 mode
);

  localparam int unsigned        FRAME_DIV  = calc_frame_div(CLK_HZ, FRAME_HZ);
  localparam int unsigned        FRAME_W    = cnt_width(FRAME_DIV);
  localparam int unsigned        PIX_W      = cnt_width(PIX_DIV);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAME_DIV - 1);
  localparam logic [PIX_W-1:0]   PIX_LAST   = PIX_W'(PIX_DIV - 1);

  logic [PIX_W-1:0]       pix_cnt_q;
  logic [PIX_W-1:0]       pix_cnt_d;
  logic                   pix_en_q;
  logic                   pix_en_d;
  logic [FRAME_W-1:0]     frame_cnt_q;
  logic [FRAME_W-1:0]     frame_cnt_d;
  logic                   raw_frame;
  logic [1:0]             mode_s1_q;
  logic [1:0]             mode_s2_q;
  mode_e                  mode_q;
  mode_e                  mode_d;
  logic                   step_pulse;
  logic                   step_level_unused;
  logic                   frame_tick_q;
  logic                   frame_tick_d;
  logic [FRAME_CNT_W-1:0] frame_count_q;
  logic [FRAME_CNT_W-1:0] frame_count_d;

  // Free-running pixel and frame dividers; they never stop so frame phase
  // is preserved across mode changes.
  always_comb begin
    pix_en_d    = (pix_cnt_q == PIX_LAST);
    pix_cnt_d   = pix_en_d ? '0 : pix_cnt_q + PIX_W'(1);
    raw_frame   = (frame_cnt_q == FRAME_LAST);
    frame_cnt_d = raw_frame ? '0 : frame_cnt_q + FRAME_W'(1);
  end

  // Switch value 11 is treated as PAUSE.
  always_comb begin
    mode_d = mode_e'(mode_s2_q);
    if (mode_s2_q == 2'b11) begin
      mode_d = MODE_PAUSE;
    end
  end

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_db (
    .clk_50mhz(clk_50mhz),
    .rst_n    (rst_n),
    .btn_in   (step_btn),
    .btn_level(step_level_unused),
    .btn_rise (step_pulse)
  );

  // The mode registered before this edge decides which source becomes the tick.
  always_comb begin
    frame_tick_d = 1'b0;
    case (mode_q)
      MODE_RUN:  frame_tick_d = raw_frame;
      MODE_STEP: frame_tick_d = step_pulse;
      default:   frame_tick_d = 1'b0;
    endcase
    frame_count_d = frame_count_q + FRAME_CNT_W'(frame_tick_q);
  end

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt_q     <= '0;
      pix_en_q      <= 1'b0;
      frame_cnt_q   <= '0;
      mode_s1_q     <= MODE_PAUSE;
      mode_s2_q     <= MODE_PAUSE;
      mode_q        <= MODE_PAUSE;
      frame_tick_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      pix_cnt_q     <= pix_cnt_d;
      pix_en_q      <= pix_en_d;
      frame_cnt_q   <= frame_cnt_d;
      mode_s1_q     <= mode_sel;
      mode_s2_q     <= mode_s1_q;
      mode_q        <= mode_d;
      frame_tick_q  <= frame_tick_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Per-channel divider: advances on frame events, ticks alongside frame_tick.
  for (genvar gi = 0; gi < CH_N; gi++) begin : g_ch
    logic [CH_DIV_W-1:0] div_c;
    logic [CH_DIV_W-1:0] last_c;
    logic [CH_DIV_W-1:0] cnt_q;
    logic [CH_DIV_W-1:0] cnt_d;
    logic                tick_q;
    logic                tick_d;

    always_comb begin
      div_c  = ch_div[gi*CH_DIV_W +: CH_DIV_W];
      last_c = (div_c == '0) ? '0 : div_c - CH_DIV_W'(1);
      tick_d = 1'b0;
      cnt_d  = cnt_q;
      if (frame_tick_d) begin
        if (cnt_q >= last_c) begin
          tick_d = 1'b1;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + CH_DIV_W'(1);
        end
      end
    end

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q  <= '0;
        tick_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        tick_q <= tick_d;
      end
    end

    assign ch_tick[gi] = tick_q;
  end

  assign pix_en      = pix_en_q;
  assign frame_tick  = frame_tick_q;
  assign frame_count = frame_count_q;
  assign mode        = mode_q;

endmodule

// File: tb/tb_game_tick_generator.sv
// Directed, table-driven bench for game_tick_generator with a 100-cycle frame.
module tb_game_tick_generator;

  localparam int unsigned CH_N     = 2;
  localparam int unsigned CH_DIV_W = 8;
  localparam int unsigned FCW      = 16;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [1:0]               mode_sel;
  logic                     step_btn;
  logic [CH_N*CH_DIV_W-1:0] ch_div;
  logic                     pix_en;
  logic                     frame_tick;
  logic [CH_N-1:0]          ch_tick;
  logic [FCW-1:0]           frame_count;
  logic [1:0]               mode;

  int unsigned cyc;
  int          n_vec;
  int          n_bad;
  int          win_ft;
  int          win_ch;
  int          win_pix;

  typedef struct {
    int unsigned cyc;
    logic        pix;
    logic        ft;
    logic [1:0]  ch;
    logic [15:0] cnt;
    logic [1:0]  md;
  } vec_t;

  vec_t tbl[$];

  game_tick_generator #(
    .CLK_HZ         (1000),
    .FRAME_HZ       (10),
    .PIX_DIV        (2),
    .DEBOUNCE_CYCLES(4),
    .CH_N           (CH_N),
    .CH_DIV_W       (CH_DIV_W),
    .FRAME_CNT_W    (FCW)
  ) dut (
    .clk_50mhz  (clk),
    .rst_n      (rst_n),
    .mode_sel   (mode_sel),
    .step_btn   (step_btn),
    .ch_div     (ch_div),
    .pix_en     (pix_en),
    .frame_tick (frame_tick),
    .ch_tick    (ch_tick),
    .frame_count(frame_count),
    .mode       (mode)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input int unsigned c, input logic p, input logic f,
                              input logic [1:0] ch, input int cnt, input logic [1:0] md);
    vec_t v;
    v.cyc = c;
    v.pix = p;
    v.ft  = f;
    v.ch  = ch;
    v.cnt = 16'(cnt);
    v.md  = md;
    return v;
  endfunction

  // pix_en is high on every even cycle after release
  function automatic logic epix(input int unsigned c);
    return (c >= 2) && (c % 2 == 0);
  endfunction

  task automatic step1();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic goto_cyc(input int unsigned c);
    while (cyc < c) step1();
  endtask

  task automatic chk_vec(input string nm, input vec_t v);
    goto_cyc(v.cyc);
    n_vec++;
    if (pix_en !== v.pix || frame_tick !== v.ft || ch_tick !== v.ch ||
        frame_count !== v.cnt || mode !== v.md) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got pix=%b ft=%b ch=%b cnt=%0d mode=%b, want pix=%b ft=%b ch=%b cnt=%0d mode=%b",
               nm, cyc, pix_en, frame_tick, ch_tick, frame_count, mode,
               v.pix, v.ft, v.ch, v.cnt, v.md);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got %0d, want %0d", nm, cyc, got, want);
    end
  endtask

  task automatic win_clear();
    win_ft  = 0;
    win_ch  = 0;
    win_pix = 0;
  endtask

  task automatic run(input int unsigned n);
    repeat (n) begin
      step1();
      win_ft  += int'(frame_tick);
      win_ch  += (ch_tick != '0) ? 1 : 0;
      win_pix += int'(pix_en);
    end
  endtask

  initial begin
    int unsigned t;
    int unsigned x;
    int unsigned nxt;

    n_vec    = 0;
    n_bad    = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    mode_sel = 2'b00;
    step_btn = 1'b0;
    ch_div   = {8'd3, 8'd0};
    win_clear();

    @(negedge clk);
    @(negedge clk);
    chk_vec("reset_state", mk(0, 0, 0, 2'b00, 0, 2'b10));
    rst_n = 1'b1;

    // RUN from release: mode sync, pixel cadence, frame and channel ticks
    tbl.push_back(mk(1,   0, 0, 2'b00, 0, 2'b10));
    tbl.push_back(mk(2,   1, 0, 2'b00, 0, 2'b10));
    tbl.push_back(mk(3,   0, 0, 2'b00, 0, 2'b00));
    tbl.push_back(mk(4,   1, 0, 2'b00, 0, 2'b00));
    tbl.push_back(mk(99,  0, 0, 2'b00, 0, 2'b00));
    tbl.push_back(mk(100, 1, 1, 2'b01, 0, 2'b00));
    tbl.push_back(mk(101, 0, 0, 2'b00, 1, 2'b00));
    tbl.push_back(mk(199, 0, 0, 2'b00, 1, 2'b00));
    tbl.push_back(mk(200, 1, 1, 2'b01, 1, 2'b00));
    tbl.push_back(mk(201, 0, 0, 2'b00, 2, 2'b00));
    tbl.push_back(mk(300, 1, 1, 2'b11, 2, 2'b00));
    tbl.push_back(mk(301, 0, 0, 2'b00, 3, 2'b00));
    tbl.push_back(mk(400, 1, 1, 2'b01, 3, 2'b00));
    tbl.push_back(mk(500, 1, 1, 2'b01, 4, 2'b00));
    tbl.push_back(mk(600, 1, 1, 2'b11, 5, 2'b00));
    tbl.push_back(mk(601, 0, 0, 2'b00, 6, 2'b00));
    for (int i = 0; i < tbl.size(); i++) begin
      chk_vec($sformatf("run_v%0d", i), tbl[i]);
    end

    // Asynchronous reset with the frame counter at 57
    chk_vec("pre_reset", mk(657, 0, 0, 2'b00, 6, 2'b00));
    rst_n = 1'b0;
    #1;
    chk_vec("reset_async", mk(657, 0, 0, 2'b00, 0, 2'b10));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    chk_vec("rst_mode",   mk(3,   0, 0, 2'b00, 0, 2'b00));
    chk_vec("rst_pre",    mk(99,  0, 0, 2'b00, 0, 2'b00));
    chk_vec("rst_tick",   mk(100, 1, 1, 2'b01, 0, 2'b00));
    chk_vec("rst_cnt",    mk(101, 0, 0, 2'b00, 1, 2'b00));

    // STEP: clean press, pulse 8 cycles after the press
    mode_sel = 2'b01;
    chk_vec("step_mode_old", mk(103, 0, 0, 2'b00, 1, 2'b00));
    chk_vec("step_mode_new", mk(104, 1, 0, 2'b00, 1, 2'b01));
    goto_cyc(110);
    step_btn = 1'b1;
    chk_vec("step_pre",  mk(117, 0, 0, 2'b00, 1, 2'b01));
    chk_vec("step_tick", mk(118, 1, 1, 2'b01, 1, 2'b01));
    chk_vec("step_cnt",  mk(119, 0, 0, 2'b00, 2, 2'b01));
    win_clear();
    run(11);
    step_btn = 1'b0;
    run(490);
    chk_int("step_no_run_ticks", win_ft, 0);
    chk_vec("step_after", mk(620, 1, 0, 2'b00, 2, 2'b01));

    // STEP: 3-cycle glitches are rejected, then a settled press ticks once
    win_clear();
    for (int g = 0; g < 3; g++) begin
      step_btn = 1'b1;
      run(3);
      step_btn = 1'b0;
      run(3);
    end
    run(10);
    chk_int("bounce_quiet", win_ft, 0);
    t = cyc;
    step_btn = 1'b1;
    chk_vec("settle_pre",  mk(t + 7, epix(t + 7), 0, 2'b00, 2, 2'b01));
    chk_vec("settle_tick", mk(t + 8, epix(t + 8), 1, 2'b11, 2, 2'b01));
    chk_vec("settle_cnt",  mk(t + 9, epix(t + 9), 0, 2'b00, 3, 2'b01));
    win_clear();
    run(30);
    chk_int("hold_single_tick", win_ft, 0);

    // PAUSE: presses and frame wraps produce nothing; pix_en keeps running
    step_btn = 1'b0;
    mode_sel = 2'b10;
    win_clear();
    run(20);
    chk_int("to_pause_quiet", win_ft, 0);
    chk_vec("pause_mode", mk(cyc, epix(cyc), 0, 2'b00, 3, 2'b10));
    win_clear();
    for (int p = 0; p < 10; p++) begin
      step_btn = 1'b1;
      run(20);
      step_btn = 1'b0;
      run(20);
    end
    run(1000);
    chk_int("pause_ft",  win_ft, 0);
    chk_int("pause_ch",  win_ch, 0);
    chk_int("pause_pix", win_pix, 700);
    chk_vec("pause_end", mk(cyc, epix(cyc), 0, 2'b00, 3, 2'b10));

    // Back to RUN: first tick at the next natural frame wrap, none earlier
    x = cyc;
    mode_sel = 2'b00;
    nxt = ((x + 4 + 99) / 100) * 100;
    win_clear();
    run(nxt - 1 - x);
    chk_int("rerun_no_early", win_ft, 0);
    chk_vec("rerun_tick", mk(nxt,     epix(nxt),     1, 2'b01, 3, 2'b00));
    chk_vec("rerun_cnt",  mk(nxt + 1, epix(nxt + 1), 0, 2'b00, 4, 2'b00));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got cyc=%0d still running, want completion", cyc);
    $fatal(1);
  end

endmodule

// File: doc/game_tick_generator.md
Name: game_tick_generator

Overview:
- Parametrised successor to the game clock block.
- Produces single-cycle clock *enables*, all on the one 50 MHz clock, instead of derived clocks:
  - a pixel enable;
  - a frame tick;
  - CH_N slower per-channel ticks derived from frame ticks;
  - a frame counter.
- Supports RUN / STEP / PAUSE modes. STEP uses a synchronised, debounced step button.
- Sits between board inputs (switches, button) and the game logic and VGA timing, which qualify their logic with these enables.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency in Hz.
- FRAME_HZ, 60, frame tick rate. FRAME_DIV = CLK_HZ/FRAME_HZ, integer division (833_333 at defaults). FRAME_DIV must be ≥ 2.
- PIX_DIV, 2, pixel enable divisor. Must be ≥ 1; a value of 1 gives pix_en constantly high after reset.
- DEBOUNCE_CYCLES, 500_000, number of cycles step_btn must be stable before it is accepted (10 ms at defaults).
- CH_N, 2, number of slow tick channels.
- CH_DIV_W, 8, width of each channel divisor.
- FRAME_CNT_W, 16, width of frame_count.

Ports:
- clk_50mhz  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- mode_sel  in  2  asynchronous switch input: 00 RUN, 01 STEP, 10 PAUSE, 11 PAUSE.
- step_btn  in  1  asynchronous, bouncing push-button, active high.
- ch_div  in  CH_N*CH_DIV_W  channel i divisor in bits [i*CH_DIV_W +: CH_DIV_W]. Quasi-static.
- pix_en  out  1  pixel enable.
- frame_tick  out  1  one-cycle game frame enable.
- ch_tick  out  CH_N  one-cycle per-channel enables.
- frame_count  out  FRAME_CNT_W  number of frame ticks since reset, wrapping.
- mode  out  2  synchronised mode in effect (11 reported as 10).

Behaviour:
- Reset:
  - All outputs are 0 and all counters are 0.
  - The debounced button level and synchroniser flops are 0.
  - The mode register is 10 (PAUSE).
  - Reset assertion mid-operation takes effect immediately.
  - After release, the first pix_en occurs on cycle PIX_DIV after release, and the first RUN frame tick on cycle FRAME_DIV after release.
- Pixel counter:
  - Counts 0..PIX_DIV-1 and wraps.
  - pix_en is registered and high for the one cycle after the counter equals PIX_DIV-1.
  - Runs in every mode.
- Frame counter:
  - Counts 0..FRAME_DIV-1, wraps, and runs in every mode, so phase is preserved across mode changes.
  - raw_frame is true when the count equals FRAME_DIV-1.
  - Entering RUN never produces an early or doubled tick; the first tick comes at the next natural wrap.
- Mode input:
  - Passes through a 2-flop synchroniser.
  - The new mode takes effect on the third clock edge after a stable change.
- Step path:
  - step_btn passes through a 2-flop synchroniser, then the debouncer.
  - The debounced level changes only after the synchronised input has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any reversion to the current level resets the stability counter to 0.
  - step_pulse is one cycle wide, on the rising edge of the debounced level only.
  - Latency from a clean press to step_pulse is 2 + DEBOUNCE_CYCLES + 1 cycles.
- frame_tick (registered, one cycle, one cycle after its source):
  - RUN: follows raw_frame.
  - STEP: follows step_pulse.
  - PAUSE: never asserted.
- Mode interactions:
  - step_pulse is discarded outside STEP mode.
  - raw_frame is discarded outside RUN mode.
  - Holding the button in STEP mode yields exactly one tick.
- frame_count increments (mod 2^FRAME_CNT_W) in the same cycle frame_tick is asserted, so the new value is visible in the cycle after the tick.
- Channel i:
  - An 8-bit counter advances only on frame tick events.
  - Let the effective divisor be d = max(ch_div_i, 1).
  - On a frame event with cnt ≥ d-1: cnt←0 and ch_tick[i] is asserted in the same cycle as frame_tick.
  - Otherwise cnt←cnt+1 and ch_tick[i] stays 0.
  - d=1 makes ch_tick[i] identical to frame_tick.
  - Lowering the divisor below the current count causes a tick on the next frame event, with no long wrap.
- Simultaneous events:
  - A mode change on the same cycle as raw_frame or step_pulse: the mode registered before that edge governs.
  - Reset overrides everything.

Decomposition:
- Package game_timing_pkg:
  - mode encodings: MODE_RUN=2'b00, MODE_STEP=2'b01, MODE_PAUSE=2'b10;
  - function computing FRAME_DIV;
  - clog2 helper for counter widths.
- Sub-module button_debouncer, holding the synchroniser, stability counter, debounced level and rising-edge pulse. It is parameter DEBOUNCE_CYCLES, with ports clk_50mhz, rst_n, btn_in, btn_level, btn_rise.
- Channel counters are generated in the top level with a generate loop.

Test Plan:
Bench parameters: CLK_HZ=1000, FRAME_HZ=10 (FRAME_DIV=100), PIX_DIV=2, DEBOUNCE_CYCLES=4, CH_N=2.
- Reset release with mode=00 → mode=00 after 3 cycles; pix_en pulses every 2nd cycle; frame_tick on cycles 100, 200, 300; frame_count reads 1, 2, 3 after each tick.
- ch_div={8'd3, 8'd0} in RUN → ch_tick[0] on every frame_tick; ch_tick[1] on frame ticks 3, 6, 9, coincident with frame_tick.
- mode=01, clean 20-cycle press → exactly one frame_tick 8 cycles after the press edge; no RUN ticks across 500 cycles.
- mode=01, button bounces with 3-cycle glitches before settling high → single frame_tick only after 4 stable cycles; glitches produce none.
- mode=10, 10 clean presses plus 1000 cycles → frame_tick, ch_tick and frame_count unchanged; pix_en continues.
- rst_n pulsed low mid-frame at count 57 → outputs 0 immediately; next RUN frame_tick exactly 100 cycles after release; frame_count restarts from 0.
